program_loader: RTL



---
 rtl/program_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words,
// writes them to consecutive memory words, then releases the core.
//
// Ports:
//   clk, reset                : clock, async active-high reset
//   start, word_count         : begin a load of word_count words
//   byte_in/valid/ready       : byte stream handshake
//   mem_addr, mem_wd, mem_we  : memory write port
//   cpu_reset, busy, done     : core hold and load status
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_SIZE:0]    word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_SIZE:0]    count_q;
  logic [ADDR_SIZE:0]    word_idx;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] wd_q;

  logic take;
  logic accept;
  logic last_word;

  assign take   = start &&
                  ((state_q == IDLE) || (state_q == DONE));
  assign accept = byte_valid && (state_q == RECV);

  // word_idx is one bit wider than the address so a full-depth
  // load finishes at the top index instead of wrapping.
  assign last_word = (word_idx ==
    (count_q - {{ADDR_SIZE{1'b0}}, 1'b1}));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (word_count == '0) state_d = DONE;
          else                  state_d = RECV;
        end
      end
      RECV: begin
        if (accept && (byte_cnt == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        if (last_word) state_d = DONE;
        else           state_d = RECV;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        count_q  <= word_count;
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (accept) begin
        wd_q     <= {wd_q[DATA_WIDTH-9:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if ((state_q == WRITE) && !last_word) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  assign byte_ready = (state_q == RECV);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = ADDR_WIDTH'(word_idx);
  assign mem_wd     = wd_q;
  assign cpu_reset  = (state_q != DONE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);

endmodule
